// File: rtl/mvau_sched_pkg.sv
// Shared types and helpers for the MVAU stream scheduler: FSM states,
// the {valid,last} tag carried alongside each issued beat, and a width helper.
package mvau_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_REUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // $clog2 that never returns 0, so single-entry counters still get a bit
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvau_sched_tagpipe.sv
// Tag shift register that tracks issued beats through the datapath latency;
// shifts only when the datapath advances, and reports whether any tag is live.
module mvau_sched_tagpipe
  import mvau_sched_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_nonempty
);

  tag_t r_stage [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < PIPE_LAT; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < PIPE_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_nonempty = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) o_nonempty = o_nonempty | r_stage[i].valid;
  end

  assign o_tag = r_stage[PIPE_LAT-1];

endmodule

// File: rtl/mvau_stream_sched.sv
// MVAU stream sequencer: buffers one input vector on the first neuron fold,
// replays it for the rest, and freezes everything under output backpressure.
// Optional MVAU_SCHED_PERF_EN adds stall_cnt / vec_cnt counters.
module mvau_stream_sched
  import mvau_sched_pkg::*;
#(
  parameter int SF       = 4,
  parameter int NF       = 2,
  parameter int PIPE_LAT = 3,
  parameter int SFW      = clog2_min1(SF),
  parameter int WAW      = clog2_min1(SF*NF)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_v,
  output logic           in_rdy,
  output logic           ibuf_wen,
  output logic [SFW-1:0] ibuf_addr,
  output logic           ibuf_rsel,
  output logic [WAW-1:0] wmem_addr,
  output logic           do_mvau_stream,
  output logic           acc_clr,
  output logic           out_v,
  input  logic           out_rdy,
  output logic           busy
`ifdef MVAU_SCHED_PERF_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [31:0]    vec_cnt
`endif
);

  localparam int             NFW     = clog2_min1(NF);
  localparam logic [SFW-1:0] SF_LAST = SFW'(SF-1);
  localparam logic [NFW-1:0] NF_LAST = NFW'(NF-1);
  localparam logic [WAW-1:0] WA_LAST = WAW'(SF*NF-1);

  state_e         r_state, w_stateNext;
  logic [SFW-1:0] r_sf, w_sfNext;
  logic [NFW-1:0] r_nf, w_nfNext;
  logic [WAW-1:0] r_waddr;
  logic           w_adv, w_issue, w_sfWrap, w_nfWrap, w_pipeNonEmpty;
  tag_t           w_issueTag, w_tailTag;

  assign w_adv    = ~(out_v & ~out_rdy);
  assign w_sfWrap = (r_sf == SF_LAST);
  assign w_nfWrap = (r_nf == NF_LAST);

  // Issue decision and counter/state successors; nothing moves without an issue
  always_comb begin
    w_stateNext = r_state;
    w_sfNext    = r_sf;
    w_nfNext    = r_nf;
    in_rdy      = 1'b0;
    ibuf_rsel   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE, S_FILL: begin
        in_rdy  = rst_n & w_adv;
        w_issue = in_v & in_rdy;
      end
      S_REUSE: begin
        ibuf_rsel = 1'b1;
        w_issue   = rst_n & w_adv;
      end
      default: ;
    endcase
    if (w_issue) begin
      w_sfNext = w_sfWrap ? '0 : r_sf + 1'b1;
      if (w_sfWrap) w_nfNext = w_nfWrap ? '0 : r_nf + 1'b1;
      if (w_sfWrap && w_nfWrap)      w_stateNext = S_IDLE;
      else if (w_sfWrap || r_nf != '0) w_stateNext = S_REUSE;
      else                            w_stateNext = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sf    <= '0;
      r_nf    <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_stateNext;
      r_sf    <= w_sfNext;
      r_nf    <= w_nfNext;
      if (w_issue) r_waddr <= (r_waddr == WA_LAST) ? '0 : r_waddr + 1'b1;
    end
  end

  assign w_issueTag     = '{valid: w_issue, last: w_sfWrap};
  assign ibuf_wen       = w_issue & (r_state != S_REUSE);
  assign acc_clr        = w_issue & (r_sf == '0);
  assign do_mvau_stream = rst_n & w_adv & (w_issue | w_pipeNonEmpty);
  assign ibuf_addr      = r_sf;
  assign wmem_addr      = r_waddr;
  assign out_v          = w_tailTag.valid & w_tailTag.last;
  assign busy           = (r_state != S_IDLE) | w_pipeNonEmpty;

  mvau_sched_tagpipe #(.PIPE_LAT(PIPE_LAT)) u_tagpipe (
    .clk       (clk),
    .i_clr     (~rst_n),
    .i_en      (do_mvau_stream),
    .i_tag     (w_issueTag),
    .o_tag     (w_tailTag),
    .o_nonempty(w_pipeNonEmpty)
  );

`ifdef MVAU_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      vec_cnt   <= '0;
    end else begin
      if (out_v & ~out_rdy & (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (out_v & out_rdy & (vec_cnt != '1))    vec_cnt   <= vec_cnt + 1'b1;
    end
  end
`endif

endmodule
